// File: rtl/proc_cache_switch_pkg.sv
// proc_cache_switch_pkg
// Shared types and constants for the processor/cache switch.
//   state_e       : transaction FSM states
//   MAX_N_CACHE   : largest supported number of cache ports
//   TIMEOUT_DATA  : fill pattern returned to the processor when a cache never answers
package proc_cache_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    BUSY   = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int MAX_N_CACHE = 8;

  // Wide enough for any sensible DATA_W; users slice the low DATA_W bits.
  localparam logic [63:0] TIMEOUT_DATA = '1;

endpackage

// File: rtl/proc_cache_switch_if.sv
// proc_cache_switch_if
// Bundles the processor-side bus and the flattened cache-bank bus.
//   master modport : the environment (processor core + cache bank models)
//   slave  modport : the switch itself
// Processor side : proc_req, proc_WE, proc_Addr, proc_DataIn -> switch;
//                  proc_DataOut, proc_ack, proc_err <- switch
// Cache side     : cache_req, cache_WE, cache_Addr, cache_DataIn <- switch;
//                  cache_DataOut, cache_ack -> switch (slice i belongs to cache i)
interface proc_cache_switch_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int N_CACHE = 2
);
  import proc_cache_switch_pkg::*;

  logic                        proc_req;
  logic                        proc_WE;
  logic [ADDR_W-1:0]           proc_Addr;
  logic [DATA_W-1:0]           proc_DataIn;
  logic [DATA_W-1:0]           proc_DataOut;
  logic                        proc_ack;
  logic                        proc_err;

  logic [N_CACHE-1:0]          cache_req;
  logic [N_CACHE-1:0]          cache_WE;
  logic [N_CACHE*ADDR_W-1:0]   cache_Addr;
  logic [N_CACHE*DATA_W-1:0]   cache_DataIn;
  logic [N_CACHE*DATA_W-1:0]   cache_DataOut;
  logic [N_CACHE-1:0]          cache_ack;

  modport master (
    output proc_req, proc_WE, proc_Addr, proc_DataIn,
    input  proc_DataOut, proc_ack, proc_err,
    input  cache_req, cache_WE, cache_Addr, cache_DataIn,
    output cache_DataOut, cache_ack
  );

  modport slave (
    input  proc_req, proc_WE, proc_Addr, proc_DataIn,
    output proc_DataOut, proc_ack, proc_err,
    output cache_req, cache_WE, cache_Addr, cache_DataIn,
    input  cache_DataOut, cache_ack
  );

endinterface

// File: rtl/proc_cache_switch_wdog.sv
// proc_cache_switch_wdog
// Counts cycles spent waiting for a cache acknowledge and flags expiry.
// Only instantiated when PROC_CACHE_SWITCH_TIMEOUT_EN is defined.
//   clk, rst : clock and synchronous active-high reset
//   start    : pulse on the cycle the FSM enters BUSY (clears the count)
//   busy     : high while the FSM is in BUSY
//   expired  : high during the TIMEOUT_CYC-th BUSY cycle
module proc_cache_switch_wdog
  import proc_cache_switch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the number of BUSY cycles already completed, so the
  // TIMEOUT_CYC-th cycle is the one where cnt == TIMEOUT_CYC-1.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      cnt <= '0;
    end else if (busy && !expired) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = busy && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/proc_cache_switch.sv
// proc_cache_switch
// Routes one processor bus to one of N_CACHE caches with registered
// request/acknowledge transactions. Cache-select changes are queued and
// applied only between transactions so an access never straddles caches.
// Optional watchdog: define PROC_CACHE_SWITCH_TIMEOUT_EN.
//   clk, rst      : clock and synchronous active-high reset
//   sel_req       : requested cache index, qualified by sel_req_valid
//   sel_active    : cache currently routed
//   sel_pending   : a switch is queued but not yet applied
//   bus (slave)   : processor bus and flattened cache-bank bus
module proc_cache_switch
  import proc_cache_switch_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int N_CACHE     = 2,
  parameter int SEL_W       = $clog2(N_CACHE),
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel_req,
  input  logic               sel_req_valid,
  output logic [SEL_W-1:0]   sel_active,
  output logic               sel_pending,
  proc_cache_switch_if.slave bus
);

  localparam logic [SEL_W:0] N_CACHE_L = (SEL_W + 1)'(N_CACHE);

  state_e            state, next_state;
  logic [SEL_W-1:0]  pending_sel;
  logic              sel_hit;
  logic              ack_sel;
  logic              expired;
  logic              start_busy;
  logic              capture_ack;
  logic              capture_to;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic [DATA_W-1:0] data_out_q;
  logic [DATA_W-1:0] rd_arr [N_CACHE];

  // Out-of-range indices are dropped here so they never reach the queue.
  assign sel_hit = sel_req_valid && ({1'b0, sel_req} < N_CACHE_L);
  assign ack_sel = bus.cache_ack[sel_active];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. An incoming strobe counts as pending in IDLE so that a
  // switch requested together with proc_req still wins over the access.
  always_comb begin
    next_state  = state;
    start_busy  = 1'b0;
    capture_ack = 1'b0;
    capture_to  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_pending || sel_hit) begin
          next_state = SWITCH;
        end else if (bus.proc_req) begin
          next_state = BUSY;
          start_busy = 1'b1;
        end
      end
      SWITCH: next_state = IDLE;
      BUSY: begin
        if (ack_sel) begin
          next_state  = RESP;
          capture_ack = 1'b1;
        end else if (expired) begin
          next_state = RESP;
          capture_to = 1'b1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Switch queue: last valid strobe wins; the queued index is applied in
  // SWITCH, and a strobe landing in SWITCH keeps the queue armed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_sel <= '0;
      sel_pending <= 1'b0;
      sel_active  <= '0;
    end else begin
      if (sel_hit) begin
        pending_sel <= sel_req;
        sel_pending <= 1'b1;
      end else if (state == SWITCH) begin
        sel_pending <= 1'b0;
      end
      if (state == SWITCH) begin
        sel_active <= pending_sel;
      end
    end
  end

  // Request capture: the processor holds these stable, but latching them
  // keeps the cache slice steady for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (start_busy) begin
      lat_we   <= bus.proc_WE;
      lat_addr <= bus.proc_Addr;
      lat_data <= bus.proc_DataIn;
    end
  end

  // Read-data register: updated on every completion (reads and writes) and
  // on a watchdog expiry; otherwise it holds its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (capture_ack) begin
      data_out_q <= rd_arr[sel_active];
    end else if (capture_to) begin
      data_out_q <= TIMEOUT_DATA[DATA_W-1:0];
    end
  end

  // Per-cache slices: only the routed cache sees a request, and only in
  // BUSY, so WE/Addr/DataIn of every other slice stay zero.
  for (genvar g = 0; g < N_CACHE; g++) begin : g_slice
    logic hit;
    assign hit                                 = (state == BUSY) && (sel_active == SEL_W'(g));
    assign bus.cache_req[g]                    = hit;
    assign bus.cache_WE[g]                     = hit && lat_we;
    assign bus.cache_Addr[g*ADDR_W +: ADDR_W]  = hit ? lat_addr : '0;
    assign bus.cache_DataIn[g*DATA_W +: DATA_W] = hit ? lat_data : '0;
    assign rd_arr[g]                           = bus.cache_DataOut[g*DATA_W +: DATA_W];
  end

  assign bus.proc_ack     = (state == RESP);
  assign bus.proc_DataOut = data_out_q;

`ifdef PROC_CACHE_SWITCH_TIMEOUT_EN
  logic err_q;

  proc_cache_switch_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .start  (start_busy),
    .busy   (state == BUSY),
    .expired(expired)
  );

  // Error flag remembers how the last access ended; exposed only with ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (capture_ack || capture_to) begin
      err_q <= capture_to;
    end
  end

  assign bus.proc_err = err_q && (state == RESP);
`else
  logic [31:0] unused_timeout_cyc;

  assign expired            = 1'b0;
  assign bus.proc_err       = 1'b0;
  assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
`endif

endmodule
